// File: rtl/mem_data_arbiter.sv
// -----------------------------------------------------------------------------
// mem_data_arbiter
//
// Purpose
//   Shares the single data port (address, write data, write enable, read data)
//   of the unified 32 x 20-bit main memory between two requesters:
//     requester 0 : pipeline memory stage
//     requester 1 : loader / debug master
//   One access is placed on the memory port per cycle. Read data is captured
//   at the end of the access cycle and returned one cycle later with a
//   one-cycle rvalid pulse. The write enable is only ever high during a
//   granted write access. The instruction-fetch port is not handled here.
//
// Configuration
//   MEM_ARB_RR_EN  defined   : round-robin; on a tie the requester that did
//                              not win last time is granted.
//   MEM_ARB_RR_EN  undefined : fixed priority; requester 0 always wins a tie.
//                              The last-winner pointer is still maintained.
//
// Ports
//   clk_i                 system clock, all state updates on posedge
//   rst_ni                asynchronous active-low reset
//   req0_i / req1_i       access request, held until the matching grant
//   we0_i  / we1_i        1 = write, 0 = read (stable while req high)
//   addr0_i / addr1_i     word address (stable while req high)
//   wdata0_i / wdata1_i   write data (stable while req high)
//   gnt0_o / gnt1_o       one-cycle pulse: command is on the memory port now
//   rvalid0_o / rvalid1_o one-cycle pulse: rdata_o holds this requester's data
//   rdata_o               registered read data, shared by both requesters
//   mem_addr_o            memory data-port address
//   mem_data_o            memory write data
//   mem_wr_en_o           memory write enable (memory writes on negedge)
//   q_mem_i               combinational read data Mem[mem_addr_o]
//   busy_o                high while an access is on the memory port
// -----------------------------------------------------------------------------
module mem_data_arbiter #(
    parameter int AW = 5,
    parameter int DW = 20
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          mem_wr_en_o,
    input  logic [DW-1:0] q_mem_i,
    output logic          busy_o
);

    // FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Requester identifiers as stored in the winner / last-winner registers
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // State and registered outputs
    logic [0:0]    state_q,     state_d;
    logic          gnt0_q,      gnt0_d;
    logic          gnt1_q,      gnt1_d;
    logic          rvalid0_q,   rvalid0_d;
    logic          rvalid1_q,   rvalid1_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_data_q,  mem_data_d;
    logic          mem_wr_en_q, mem_wr_en_d;
    logic          last_q,      last_d;   // most recent winner
    logic          win_q,       win_d;    // owner of the access on the port
    logic          rd_q,        rd_d;     // access on the port is a read

    // Combinational arbitration signals
    logic          elig0_s;
    logic          elig1_s;
    logic          any_elig_s;
    logic          win_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Eligibility: a requester that is being shown its grant right now still
    // has req high for that cycle, so it must not be counted again.
    always_comb begin
        elig0_s    = req0_i & ~gnt0_q;
        elig1_s    = req1_i & ~gnt1_q;
        any_elig_s = elig0_s | elig1_s;
    end

    // Winner selection. With nobody eligible the result is unused, so the
    // pointer value is passed through rather than inventing a constant.
    always_comb begin
        win_s = last_q;
`ifdef MEM_ARB_RR_EN
        if (elig0_s && elig1_s) begin
            win_s = ~last_q;
        end else if (elig0_s) begin
            win_s = REQ0;
        end else if (elig1_s) begin
            win_s = REQ1;
        end else begin
            win_s = last_q;
        end
`else
        if (elig0_s) begin
            win_s = REQ0;
        end else if (elig1_s) begin
            win_s = REQ1;
        end else begin
            win_s = last_q;
        end
`endif
    end

    // Command multiplexer driven by the selected winner
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        if (win_s == REQ1) begin
            sel_we_s    = we1_i;
            sel_addr_s  = addr1_i;
            sel_wdata_s = wdata1_i;
        end else begin
            sel_we_s    = we0_i;
            sel_addr_s  = addr0_i;
            sel_wdata_s = wdata0_i;
        end
    end

    // Next-state logic: complete the access on the port, then arbitrate
    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wr_en_d = mem_wr_en_q;
        last_d      = last_q;
        win_d       = win_q;
        rd_d        = rd_q;

        // Completion of the current access. rdata only changes on a read,
        // so it keeps the last read result across writes and idle cycles.
        case (state_q)
            ST_IDLE: begin
                rdata_d = rdata_q;
            end
            ST_ACCESS: begin
                if (rd_q) begin
                    rdata_d = q_mem_i;
                    if (win_q == REQ1) begin
                        rvalid1_d = 1'b1;
                    end else begin
                        rvalid0_d = 1'b1;
                    end
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                rdata_d = rdata_q;
            end
        endcase

        // Arbitration is identical from IDLE and ACCESS; issuing from ACCESS
        // gives back-to-back accesses without an idle bubble.
        if (any_elig_s) begin
            state_d     = ST_ACCESS;
            mem_addr_d  = sel_addr_s;
            mem_data_d  = sel_wdata_s;
            mem_wr_en_d = sel_we_s;
            last_d      = win_s;
            win_d       = win_s;
            rd_d        = ~sel_we_s;
            if (win_s == REQ1) begin
                gnt1_d = 1'b1;
            end else begin
                gnt0_d = 1'b1;
            end
        end else begin
            // Address and data hold their last values in IDLE
            state_d     = ST_IDLE;
            mem_wr_en_d = 1'b0;
            rd_d        = 1'b0;
        end
    end

    // State registers; reset aborts any access and drops the write enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= {DW{1'b0}};
            mem_addr_q  <= {AW{1'b0}};
            mem_data_q  <= {DW{1'b0}};
            mem_wr_en_q <= 1'b0;
            last_q      <= REQ1;
            win_q       <= REQ0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wr_en_q <= mem_wr_en_d;
            last_q      <= last_d;
            win_q       <= win_d;
            rd_q        <= rd_d;
        end
    end

    // All outputs come straight from registers
    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign busy_o      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_data_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_data_arbiter
//
// Self-checking bench for mem_data_arbiter. A 32-word memory lives in the
// bench (writes on negedge, combinational read). A transaction-level model
// predicts grants, memory contents and read returns from the arbitration
// rules. Build with +define+MEM_ARB_RR_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_mem_data_arbiter;

    localparam int AW = 5;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy;
    logic [DW-1:0] rdata, mem_data, q_mem;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem     [32];
    logic [DW-1:0] exp_mem [32];
    logic          do_preload = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the DUT outputs should be in the current cycle
    logic          m_gnt0, m_gnt1, m_rv0, m_rv1, m_we, m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata;
    int            m_last, m_who;

    mem_data_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_wr_en_o(mem_wr_en), .q_mem_i(q_mem), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 29) return 20'h00003;
        return 20'h0F000 + DW'(i);
    endfunction

    // Memory: preload, then write on negedge when enabled
    always @(negedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_data;
        end
    end
    assign q_mem = mem[mem_addr];

    task automatic model_reset();
        m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_we = 1'b0; m_busy = 1'b0; m_addr = '0; m_data = '0; m_rdata = '0;
        m_last = 1; m_who = 0;
    endtask

    // Advance the model by one edge using the requests presented right now
    task automatic model_next();
        bit e0, e1;
        int w;
        // A read currently on the port returns its data next cycle
        m_rv0 = 1'b0; m_rv1 = 1'b0;
        if (m_busy && !m_we) begin
            m_rdata = exp_mem[m_addr];
            if (m_who == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
        end
        // A requester shown its grant this cycle cannot win again yet
        e0 = req0 && !m_gnt0;
        e1 = req1 && !m_gnt1;
        w = -1;
`ifdef MEM_ARB_RR_EN
        if (e0 && e1) w = (m_last == 0) ? 1 : 0;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
`else
        if (e0)      w = 0;
        else if (e1) w = 1;
`endif
        m_gnt0 = (w == 0);
        m_gnt1 = (w == 1);
        if (w < 0) begin
            m_busy = 1'b0; m_we = 1'b0;
        end else begin
            m_busy = 1'b1; m_last = w; m_who = w;
            m_addr = (w == 1) ? addr1  : addr0;
            m_data = (w == 1) ? wdata1 : wdata0;
            m_we   = (w == 1) ? we1    : we0;
            if (m_we) exp_mem[m_addr] = m_data;
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; do_preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_preload = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = init_word(i);
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected %b", {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy}, 6'b0);
        end
        n_cmp++;
        if ({mem_addr, mem_data, rdata} !== {(AW+2*DW){1'b0}}) begin
            n_err++; $display("FAIL reset_data: got addr=%h data=%h rdata=%h expected all zero", mem_addr, mem_data, rdata);
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_release: got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h10; wdata0 = 20'h0ABCD;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, mem_wr_en, busy} !== 4'b1011 || mem_addr !== 5'h10 || mem_data !== 20'h0ABCD) begin
            n_err++; $display("FAIL wr_grant: got gnt=%b%b we=%b busy=%b addr=%h data=%h expected 1 0 1 1 10 0abcd", gnt0, gnt1, mem_wr_en, busy, mem_addr, mem_data);
        end
        we0 = 1'b0;
        tick();
        n_cmp++;
        if ({gnt0, mem_wr_en, busy} !== 3'b000) begin
            n_err++; $display("FAIL wr_mask: got %b expected 000", {gnt0, mem_wr_en, busy});
        end
        tick();
        n_cmp++;
        if ({gnt0, mem_wr_en, busy} !== 3'b101) begin
            n_err++; $display("FAIL rd_grant: got %b expected 101", {gnt0, mem_wr_en, busy});
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 20'h0ABCD) begin
            n_err++; $display("FAIL rd_return: got rv0=%b rv1=%b rdata=%h expected 1 0 0abcd", rvalid0, rvalid1, rdata);
        end
        n_cmp++;
        if (mem[16] !== 20'h0ABCD) begin
            n_err++; $display("FAIL wr_mem: got %h expected 0abcd", mem[16]);
        end
    endtask

    task automatic test_cross_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1D;
        tick();
        n_cmp++;
        if ({gnt0, gnt1, mem_wr_en} !== 3'b010) begin
            n_err++; $display("FAIL cross_grant: got %b expected 010", {gnt0, gnt1, mem_wr_en});
        end
        req1 = 1'b0;
        tick();
        n_cmp++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 20'h00003) begin
            n_err++; $display("FAIL cross_return: got rv1=%b rv0=%b rdata=%h expected 1 0 00003", rvalid1, rvalid0, rdata);
        end
        tick();
        n_cmp++;
        if (rvalid1 !== 1'b0 || rdata !== 20'h00003) begin
            n_err++; $display("FAIL rdata_hold: got rv1=%b rdata=%h expected 0 00003", rvalid1, rdata);
        end
    endtask

    task automatic test_simultaneous();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h03;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({gnt0, gnt1, busy} !== {(i % 2 == 0), (i % 2 == 1), 1'b1}) begin
                n_err++; $display("FAIL simul_grant%0d: got gnt0/gnt1/busy=%b expected %b", i, {gnt0, gnt1, busy}, {(i % 2 == 0), (i % 2 == 1), 1'b1});
            end
            if (i == 2) req0 = 1'b0;
            if (i == 3) req1 = 1'b0;
        end
        tick();
        n_cmp++;
        if ({rvalid1, busy} !== 2'b10 || rdata !== init_word(4)) begin
            n_err++; $display("FAIL simul_drain: got rv1/busy=%b rdata=%h expected 10 %h", {rvalid1, busy}, rdata, init_word(4));
        end
    endtask

    // After requester 0 wins alone, a tie separates the two policies
    task automatic test_priority();
        logic exp_first0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h01;
        tick();
        req0 = 1'b0;
        tick();
`ifdef MEM_ARB_RR_EN
        exp_first0 = 1'b0;
`else
        exp_first0 = 1'b1;
`endif
        req0 = 1'b1; addr0 = 5'h02;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h05;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== {exp_first0, ~exp_first0}) begin
            n_err++; $display("FAIL tie_winner: got %b expected %b", {gnt0, gnt1}, {exp_first0, ~exp_first0});
        end
        if (exp_first0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        n_cmp++;
        if ({gnt0, gnt1} !== {~exp_first0, exp_first0}) begin
            n_err++; $display("FAIL tie_second: got %b expected %b", {gnt0, gnt1}, {~exp_first0, exp_first0});
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h05;
        tick();
        n_cmp++;
        if ({gnt0, busy} !== 2'b11) begin
            n_err++; $display("FAIL b2b_first: got %b expected 11", {gnt0, busy});
        end
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h02; wdata1 = 20'h12345;
        tick();
        n_cmp++;
        if ({gnt1, busy, mem_wr_en, rvalid0} !== 4'b1111 || mem_addr !== 5'h02 || rdata !== init_word(5)) begin
            n_err++; $display("FAIL b2b_second: got gnt1/busy/we/rv0=%b addr=%h rdata=%h expected 1111 02 %h", {gnt1, busy, mem_wr_en, rvalid0}, mem_addr, rdata, init_word(5));
        end
        req1 = 1'b0;
        tick();
        n_cmp++;
        if (mem[2] !== 20'h12345 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_mem: got mem=%h busy=%b expected 12345 0", mem[2], busy);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [DW-1:0] old;
        old = mem[7];
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h07; wdata0 = 20'h55555;
        tick();
        n_cmp++;
        if ({gnt0, mem_wr_en} !== 2'b11) begin
            n_err++; $display("FAIL abort_setup: got %b expected 11", {gnt0, mem_wr_en});
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy} !== 6'b0 || {mem_addr, mem_data, rdata} !== {(AW+2*DW){1'b0}}) begin
            n_err++; $display("FAIL abort_outputs: got ctrl=%b addr=%h data=%h rdata=%h expected all zero", {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy}, mem_addr, mem_data, rdata);
        end
        req0 = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (mem[7] !== old) begin
            n_err++; $display("FAIL abort_mem: got %h expected %h", mem[7], old);
        end
        rst_n = 1'b1;
        exp_mem[7] = old;
        model_reset();
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy} !== 6'b0) begin
                n_err++; $display("FAIL idle%0d: got %b expected 000000", i, {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick();
            n_cmp++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy} !== {m_gnt0, m_gnt1, m_rv0, m_rv1, m_we, m_busy}) begin
                n_err++; $display("FAIL rand_ctrl@%0d: got %b expected %b", c, {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy}, {m_gnt0, m_gnt1, m_rv0, m_rv1, m_we, m_busy});
            end
            n_cmp++;
            if (mem_addr !== m_addr || mem_data !== m_data) begin
                n_err++; $display("FAIL rand_port@%0d: got %h/%h expected %h/%h", c, mem_addr, mem_data, m_addr, m_data);
            end
            n_cmp++;
            if (rdata !== m_rdata) begin
                n_err++; $display("FAIL rand_rdata@%0d: got %h expected %h", c, rdata, m_rdata);
            end
            // Requesters react to grants: reissue, drop, or start a request
            if (gnt0) begin
                req0 = 1'($urandom_range(0, 1));
                we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom_range(0, 7)); wdata0 = 20'($urandom);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1;
                we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom_range(0, 7)); wdata0 = 20'($urandom);
            end
            if (gnt1) begin
                req1 = 1'($urandom_range(0, 1));
                we1 = 1'($urandom_range(0, 1)); addr1 = 5'($urandom_range(0, 7)); wdata1 = 20'($urandom);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                we1 = 1'($urandom_range(0, 1)); addr1 = 5'($urandom_range(0, 7)); wdata1 = 20'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (mem[i] !== exp_mem[i]) begin
                n_err++; $display("FAIL mem_image[%0d]: got %h expected %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_cross_read();
        test_simultaneous();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
